tlu_handshake_fsm: RTL and testbench

Trigger-domain sequencer that owns the TLU handshake inside the TLU controller core. It accepts triggers from the external trigger path or the TLU trigger line. Per the selected mode, it drives TLU_BUSY and TLU_CLOCK, serially shifts in the TLU trigger number, and holds off re-arming until the readout sequencer acknowledges. It sits between the trigger/veto logic and the trigger-number FIFO writer, clocked entirely by TRIGGER_CLK.

---
 rtl/tlu_pkg.sv | 21 ++
 rtl/tlu_trigger_shift_rx.sv | 85 ++++++++
 rtl/tlu_handshake_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_tlu_handshake_fsm.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_pkg.sv
// tlu_pkg
// Shared definitions for the TLU handshake sequencer: trigger mode encodings,
// the handshake FSM state type and the trigger-number width.
package tlu_pkg;

  localparam int TLU_NUMBER_WIDTH = 32;

  localparam logic [1:0] TLU_MODE_EXT       = 2'd0;
  localparam logic [1:0] TLU_MODE_NO_HS     = 2'd1;
  localparam logic [1:0] TLU_MODE_SIMPLE_HS = 2'd2;
  localparam logic [1:0] TLU_MODE_DATA_HS   = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOW = 3'd1,
    SHIFT    = 3'd2,
    DONE     = 3'd3,
    WAIT_ACK = 3'd4
  } tlu_state_t;

endpackage

// File: rtl/tlu_trigger_shift_rx.sv
// tlu_trigger_shift_rx
// Serial receiver for the TLU trigger number. A start pulse launches
// TRIGGER_BITS periods of TLU_CLOCK (DIVISOR/2 cycles high, DIVISOR/2 low),
// sampling serial_in in the last high cycle of each period, MSB first.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse; first TLU_CLOCK high cycle follows it
//   serial_in   : TLU serial data line
//   tlu_clock   : shift clock to the TLU, idle low
//   done        : high in the final cycle of the transfer (combinational)
//   data        : received number, complete when done is high
module tlu_trigger_shift_rx #(
  parameter int DIVISOR      = 8,
  parameter int TRIGGER_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    serial_in,
  output logic                    tlu_clock,
  output logic                    done,
  output logic [TRIGGER_BITS-1:0] data
);

  localparam int PHASE_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W   = (TRIGGER_BITS > 1) ? $clog2(TRIGGER_BITS) : 1;

  localparam logic [PHASE_W-1:0] LAST_HIGH  = PHASE_W'(DIVISOR / 2 - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(TRIGGER_BITS - 1);

  logic                    active_q;
  logic [PHASE_W-1:0]      phase_q;
  logic [BIT_W-1:0]        bit_q;
  logic                    clock_q;
  logic [TRIGGER_BITS-1:0] data_q;
  logic [TRIGGER_BITS-1:0] shifted;

  // Next shift-register value with the current line level appended as LSB
  always_comb begin
    shifted    = data_q << 1;
    shifted[0] = serial_in;
  end

  // Period/bit counters; the clock is registered so its first high cycle
  // coincides with the first SHIFT cycle of the parent FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      bit_q    <= '0;
      clock_q  <= 1'b0;
      data_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      phase_q  <= '0;
      bit_q    <= '0;
      clock_q  <= 1'b1;
      data_q   <= '0;
    end else if (active_q) begin
      if (phase_q == LAST_HIGH) begin
        data_q  <= shifted;
        clock_q <= 1'b0;
      end
      if (phase_q == LAST_PHASE) begin
        phase_q <= '0;
        if (bit_q == LAST_BIT) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 1'b1;
          clock_q <= 1'b1;
        end
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  // done is combinational so the parent leaves SHIFT after exactly
  // TRIGGER_BITS*DIVISOR cycles
  assign done      = active_q && (phase_q == LAST_PHASE) && (bit_q == LAST_BIT);
  assign tlu_clock = clock_q;
  assign data      = data_q;

endmodule

// File: rtl/tlu_handshake_fsm.sv
// tlu_handshake_fsm
// Trigger-domain sequencer owning the TLU handshake. Accepts a trigger edge
// from EXT_TRIGGER (mode 0) or TLU_TRIGGER (modes 1-3), drives TLU_BUSY and
// TLU_CLOCK per the latched mode, optionally shifts in the TLU trigger number,
// and waits for the readout acknowledge before re-arming.
// Ports:
//   TRIGGER_CLK, TRIGGER_RST_N : clock, asynchronous active-low reset
//   TRIGGER_MODE               : 0 ext, 1 TLU no hs, 2 simple hs, 3 data hs
//   TRIGGER_ENABLE             : arms acceptance of new triggers in IDLE
//   EXT_TRIGGER, TLU_TRIGGER   : synchronous trigger inputs
//   TRIGGER_ACKNOWLEDGE        : readout-done pulse/level
//   LOW_TIMEOUT                : mode-3 wait-for-low limit, 0 = no limit
//   TLU_BUSY, TLU_CLOCK        : handshake lines to the TLU
//   TRIGGER_ACCEPTED_FLAG      : one-cycle pulse per accepted trigger
//   TRIGGER_NUMBER(_VALID)     : trigger number and its one-cycle strobe
//   TIMEOUT_ERROR              : one-cycle pulse on mode-3 low-wait timeout
//   BUSY                       : FSM not in IDLE
module tlu_handshake_fsm
  import tlu_pkg::*;
#(
  parameter int DIVISOR      = 8,
  parameter int TRIGGER_BITS = 16
) (
  input  logic                        TRIGGER_CLK,
  input  logic                        TRIGGER_RST_N,
  input  logic [1:0]                  TRIGGER_MODE,
  input  logic                        TRIGGER_ENABLE,
  input  logic                        EXT_TRIGGER,
  input  logic                        TLU_TRIGGER,
  input  logic                        TRIGGER_ACKNOWLEDGE,
  input  logic [7:0]                  LOW_TIMEOUT,
  output logic                        TLU_BUSY,
  output logic                        TLU_CLOCK,
  output logic                        TRIGGER_ACCEPTED_FLAG,
  output logic [TLU_NUMBER_WIDTH-1:0] TRIGGER_NUMBER,
  output logic                        TRIGGER_NUMBER_VALID,
  output logic                        TIMEOUT_ERROR,
  output logic                        BUSY
);

  tlu_state_t                  state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic [TLU_NUMBER_WIDTH-1:0] counter_q, counter_d;
  logic [TLU_NUMBER_WIDTH-1:0] number_q, number_d;
  logic                        accepted_q, accepted_d;
  logic                        valid_q, valid_d;
  logic                        timeout_q, timeout_d;
  logic                        tlu_busy_q, tlu_busy_d;
  logic [7:0]                  low_cnt_q, low_cnt_d;
  logic                        ack_seen_q, ack_seen_d;
  logic                        src_q;
  logic                        src;
  logic                        rise;
  logic                        shift_start;
  logic                        shift_done;
  logic [TRIGGER_BITS-1:0]     rx_data;
  logic [TLU_NUMBER_WIDTH-1:0] rx_number;

  assign src  = (TRIGGER_MODE == TLU_MODE_EXT) ? EXT_TRIGGER : TLU_TRIGGER;
  assign rise = src & ~src_q;

  tlu_trigger_shift_rx #(
    .DIVISOR      (DIVISOR),
    .TRIGGER_BITS (TRIGGER_BITS)
  ) u_shift_rx (
    .clk       (TRIGGER_CLK),
    .rst_n     (TRIGGER_RST_N),
    .start     (shift_start),
    .serial_in (TLU_TRIGGER),
    .tlu_clock (TLU_CLOCK),
    .done      (shift_done),
    .data      (rx_data)
  );

  // Zero-extend the received number to the full trigger-number width
  always_comb begin
    rx_number                     = '0;
    rx_number[TRIGGER_BITS-1:0]   = rx_data;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    counter_d   = counter_q;
    number_d    = number_q;
    accepted_d  = 1'b0;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    tlu_busy_d  = tlu_busy_q;
    low_cnt_d   = low_cnt_q;
    ack_seen_d  = ack_seen_q;
    shift_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise && TRIGGER_ENABLE) begin
          mode_d = TRIGGER_MODE;
          unique case (TRIGGER_MODE)
            TLU_MODE_EXT, TLU_MODE_NO_HS, TLU_MODE_SIMPLE_HS: begin
              state_d    = WAIT_ACK;
              accepted_d = 1'b1;
              valid_d    = 1'b1;
              number_d   = counter_q;
              counter_d  = counter_q + 32'd1;
              tlu_busy_d = (TRIGGER_MODE == TLU_MODE_SIMPLE_HS);
            end
            TLU_MODE_DATA_HS: begin
              state_d    = WAIT_LOW;
              tlu_busy_d = 1'b1;
              low_cnt_d  = '0;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      // Mode 2 waits here after the ack; mode 3 waits here before shifting
      // and is the only mode subject to the low-wait timeout
      WAIT_LOW: begin
        if (!TLU_TRIGGER) begin
          if (mode_q == TLU_MODE_DATA_HS) begin
            state_d     = SHIFT;
            shift_start = 1'b1;
          end else begin
            state_d    = IDLE;
            tlu_busy_d = 1'b0;
          end
        end else if (mode_q == TLU_MODE_DATA_HS) begin
          low_cnt_d = low_cnt_q + 8'd1;
          if ((LOW_TIMEOUT != 8'd0) && (low_cnt_d == LOW_TIMEOUT)) begin
            state_d    = IDLE;
            timeout_d  = 1'b1;
            tlu_busy_d = 1'b0;
          end
        end
      end

      SHIFT: begin
        if (shift_done) begin
          state_d    = DONE;
          accepted_d = 1'b1;
          valid_d    = 1'b1;
          number_d   = rx_number;
          counter_d  = counter_q + 32'd1;
        end
      end

      DONE: state_d = WAIT_ACK;

      WAIT_ACK: begin
        if (ack_seen_q || TRIGGER_ACKNOWLEDGE) begin
          if (mode_q == TLU_MODE_SIMPLE_HS) begin
            state_d = WAIT_LOW;
          end else begin
            state_d    = IDLE;
            tlu_busy_d = 1'b0;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        tlu_busy_d = 1'b0;
      end
    endcase

    // An acknowledge seen in any busy state is remembered until IDLE so an
    // early readout-done during WAIT_LOW/SHIFT is not lost
    if (state_d == IDLE) begin
      ack_seen_d = 1'b0;
    end else if (state_q != IDLE) begin
      ack_seen_d = ack_seen_q | TRIGGER_ACKNOWLEDGE;
    end
  end

  // State and output registers; src_q tracks the source every cycle so a
  // level held through a transaction cannot re-trigger on return to IDLE
  always_ff @(posedge TRIGGER_CLK or negedge TRIGGER_RST_N) begin
    if (!TRIGGER_RST_N) begin
      state_q    <= IDLE;
      mode_q     <= TLU_MODE_EXT;
      counter_q  <= '0;
      number_q   <= '0;
      accepted_q <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      tlu_busy_q <= 1'b0;
      low_cnt_q  <= '0;
      ack_seen_q <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      counter_q  <= counter_d;
      number_q   <= number_d;
      accepted_q <= accepted_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      tlu_busy_q <= tlu_busy_d;
      low_cnt_q  <= low_cnt_d;
      ack_seen_q <= ack_seen_d;
      src_q      <= src;
    end
  end

  assign TLU_BUSY              = tlu_busy_q;
  assign TRIGGER_ACCEPTED_FLAG = accepted_q;
  assign TRIGGER_NUMBER_VALID  = valid_q;
  assign TRIGGER_NUMBER        = number_q;
  assign TIMEOUT_ERROR         = timeout_q;
  assign BUSY                  = (state_q != IDLE);

endmodule

// File: tb/tb_tlu_handshake_fsm.sv
// tb_tlu_handshake_fsm
// Self-checking bench: each transaction type is driven by a task that knows
// the expected cycle-by-cycle response from the handshake rules, with a
// running trigger-counter model for expected trigger numbers.
module tb_tlu_handshake_fsm;

  localparam int DIV = 8;
  localparam int NB  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        enable;
  logic        ext_trig;
  logic        tlu_trig;
  logic        ack;
  logic [7:0]  low_timeout;
  logic        tlu_busy;
  logic        tlu_clock;
  logic        acc_flag;
  logic [31:0] number;
  logic        num_valid;
  logic        timeout_err;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  tlu_handshake_fsm #(
    .DIVISOR      (DIV),
    .TRIGGER_BITS (NB)
  ) dut (
    .TRIGGER_CLK           (clk),
    .TRIGGER_RST_N         (rst_n),
    .TRIGGER_MODE          (mode),
    .TRIGGER_ENABLE        (enable),
    .EXT_TRIGGER           (ext_trig),
    .TLU_TRIGGER           (tlu_trig),
    .TRIGGER_ACKNOWLEDGE   (ack),
    .LOW_TIMEOUT           (low_timeout),
    .TLU_BUSY              (tlu_busy),
    .TLU_CLOCK             (tlu_clock),
    .TRIGGER_ACCEPTED_FLAG (acc_flag),
    .TRIGGER_NUMBER        (number),
    .TRIGGER_NUMBER_VALID  (num_valid),
    .TIMEOUT_ERROR         (timeout_err),
    .BUSY                  (busy)
  );

  always #5 clk = ~clk;

  // Hard stop if something wedges the run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int m, input logic v);
    if (m == 0) ext_trig = v;
    else        tlu_trig = v;
  endtask

  // Mode 0/1: accept next cycle, number = counter, TLU_BUSY never asserted
  task automatic run_ext(input int m, input int ack_delay);
    mode = 2'(m);
    set_src(m, 1'b1);
    tick();
    checkOutput("ext_flag", acc_flag, 1);
    checkOutput("ext_valid", num_valid, 1);
    checkOutput("ext_number", number, exp_cnt);
    checkOutput("ext_tlu_busy", tlu_busy, 0);
    exp_cnt++;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      checkOutput("ext_wait_busy", busy, 1);
      checkOutput("ext_wait_flag", acc_flag, 0);
      checkOutput("ext_wait_tlu_busy", tlu_busy, 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("ext_idle_busy", busy, 0);
    checkOutput("ext_idle_tlu_busy", tlu_busy, 0);
    tick();
    tick();
    checkOutput("ext_held_no_retrig", acc_flag, 0);
    set_src(m, 1'b0);
    tick();
  endtask

  // Mode 2: BUSY from accept until TLU_TRIGGER low after the ack
  task automatic run_simple_hs(input int ack_delay, input int extra_high, input bit drop_before_ack);
    mode = 2'd2;
    tlu_trig = 1'b1;
    tick();
    checkOutput("shs_flag", acc_flag, 1);
    checkOutput("shs_number", number, exp_cnt);
    checkOutput("shs_tlu_busy", tlu_busy, 1);
    exp_cnt++;
    // Same trigger source, so a live mode change must not alter this transaction
    mode = 2'd3;
    if (drop_before_ack) tlu_trig = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      checkOutput("shs_wait_ack_tlu_busy", tlu_busy, 1);
      checkOutput("shs_wait_ack_flag", acc_flag, 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("shs_wait_low_tlu_busy", tlu_busy, 1);
    checkOutput("shs_wait_low_busy", busy, 1);
    if (!drop_before_ack) begin
      for (int i = 0; i < extra_high; i++) begin
        tick();
        checkOutput("shs_held_tlu_busy", tlu_busy, 1);
        checkOutput("shs_held_timeout", timeout_err, 0);
      end
    end
    tlu_trig = 1'b0;
    tick();
    checkOutput("shs_release_tlu_busy", tlu_busy, 0);
    checkOutput("shs_release_busy", busy, 0);
    mode = 2'd2;
    tick();
  endtask

  // Mode 3: wait-for-low, serial shift of 'value', then ack handling.
  // ack_at < 0 means the ack is given after DONE, post cycles later.
  task automatic run_data_hs(input logic [NB-1:0] value, input int hold, input int ack_at, input int post);
    int   pulses;
    logic prev;
    logic b;
    mode = 2'd3;
    tlu_trig = 1'b1;
    tick();
    checkOutput("dhs_tlu_busy", tlu_busy, 1);
    checkOutput("dhs_no_flag", acc_flag, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("dhs_hold_timeout", timeout_err, 0);
      checkOutput("dhs_hold_busy", busy, 1);
    end
    tlu_trig = 1'b0;
    tick();
    pulses = 0;
    prev   = 1'b0;
    for (int k = 0; k < NB * DIV; k++) begin
      checkOutput("dhs_tlu_clock", tlu_clock, 32'(((k % DIV) < (DIV / 2)) ? 1 : 0));
      checkOutput("dhs_shift_flag", acc_flag, 0);
      if (tlu_clock && !prev) pulses++;
      prev = tlu_clock;
      b = value[NB - 1 - k / DIV];
      // Present the real bit only in the sampling cycle
      tlu_trig = ((k % DIV) == (DIV / 2 - 1)) ? b : ~b;
      ack = (k == ack_at);
      tick();
    end
    ack = 1'b0;
    tlu_trig = 1'b0;
    checkOutput("dhs_clock_pulses", pulses, NB);
    checkOutput("dhs_done_flag", acc_flag, 1);
    checkOutput("dhs_done_valid", num_valid, 1);
    checkOutput("dhs_number", number, 32'(value));
    checkOutput("dhs_done_tlu_busy", tlu_busy, 1);
    checkOutput("dhs_done_tlu_clock", tlu_clock, 0);
    exp_cnt++;
    tick();
    checkOutput("dhs_wait_ack_busy", busy, 1);
    checkOutput("dhs_wait_ack_flag", acc_flag, 0);
    if (ack_at < 0) begin
      for (int i = 0; i < post; i++) begin
        tick();
        checkOutput("dhs_post_tlu_busy", tlu_busy, 1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end else begin
      tick();
    end
    checkOutput("dhs_end_busy", busy, 0);
    checkOutput("dhs_end_tlu_busy", tlu_busy, 0);
    tick();
  endtask

  // Mode 3 with TLU_TRIGGER stuck high: timeout L cycles after WAIT_LOW entry
  task automatic run_timeout(input int lim);
    low_timeout = 8'(lim);
    mode = 2'd3;
    tlu_trig = 1'b1;
    tick();
    for (int i = 0; i < lim; i++) begin
      checkOutput("to_early", timeout_err, 0);
      checkOutput("to_wait_tlu_busy", tlu_busy, 1);
      tick();
    end
    checkOutput("to_pulse", timeout_err, 1);
    checkOutput("to_no_valid", num_valid, 0);
    checkOutput("to_no_flag", acc_flag, 0);
    tick();
    checkOutput("to_pulse_end", timeout_err, 0);
    checkOutput("to_tlu_busy", tlu_busy, 0);
    checkOutput("to_busy", busy, 0);
    tlu_trig = 1'b0;
    tick();
  endtask

  // One randomized transaction, optionally preceded by a stray ack in IDLE
  task automatic applyStimulus();
    int kind;
    int lim;
    int hold;
    int ack_at;
    if ($urandom_range(0, 3) == 0) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    tick();
    kind = $urandom_range(0, 4);
    case (kind)
      0, 1: run_ext(kind, $urandom_range(0, 4));
      2: run_simple_hs($urandom_range(0, 4), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      3: begin
        lim = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 20);
        low_timeout = 8'(lim);
        hold = (lim == 0) ? $urandom_range(0, 30) : $urandom_range(0, lim - 1);
        ack_at = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, NB * DIV - 1);
        run_data_hs(NB'($urandom_range(0, 65535)), hold, ack_at, $urandom_range(0, 4));
      end
      default: run_timeout($urandom_range(1, 15));
    endcase
  endtask

  initial begin
    rst_n       = 1'b0;
    mode        = 2'd0;
    enable      = 1'b1;
    ext_trig    = 1'b0;
    tlu_trig    = 1'b0;
    ack         = 1'b0;
    low_timeout = 8'd0;
    #12;
    checkOutput("rst_tlu_busy", tlu_busy, 0);
    checkOutput("rst_tlu_clock", tlu_clock, 0);
    checkOutput("rst_flag", acc_flag, 0);
    checkOutput("rst_number", number, 0);
    checkOutput("rst_valid", num_valid, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // External trigger: numbers 0 then 1
    run_ext(0, 2);
    run_ext(0, 1);

    // Data handshake 0xA5C3, TLU releases 3 cycles after BUSY
    low_timeout = 8'd0;
    run_data_hs(16'hA5C3, 3, -1, 4);

    // Low-wait timeout, then unlimited wait with timeout disabled
    run_timeout(10);
    low_timeout = 8'd0;
    run_data_hs(NB'($urandom_range(0, 65535)), 300, -1, 2);

    // Simple handshake with ack while trigger is still high
    low_timeout = 8'd5;
    run_simple_hs(2, 8, 1'b0);
    run_simple_hs(0, 0, 1'b0);

    // Ack arriving mid-shift
    low_timeout = 8'd0;
    run_data_hs(NB'($urandom_range(0, 65535)), 1, 40, 0);

    // Disabled: a rise is ignored and the held level does not fire on re-enable
    enable = 1'b0;
    mode = 2'd0;
    ext_trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("dis_no_flag", acc_flag, 0);
      checkOutput("dis_busy", busy, 0);
    end
    enable = 1'b1;
    tick();
    tick();
    checkOutput("dis_reenable_no_flag", acc_flag, 0);
    ext_trig = 1'b0;
    tick();

    // Enable dropped right after accept still completes normally
    mode = 2'd1;
    tlu_trig = 1'b1;
    tick();
    checkOutput("endrop_flag", acc_flag, 1);
    checkOutput("endrop_number", number, exp_cnt);
    exp_cnt++;
    enable = 1'b0;
    tick();
    checkOutput("endrop_busy", busy, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("endrop_idle", busy, 0);
    tlu_trig = 1'b0;
    enable = 1'b1;
    tick();

    for (int n = 0; n < 30; n++) applyStimulus();

    // Asynchronous reset in the middle of a shift
    low_timeout = 8'd0;
    mode = 2'd3;
    tlu_trig = 1'b1;
    tick();
    tlu_trig = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      tlu_trig = 1'($urandom_range(0, 1));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tlu_busy", tlu_busy, 0);
    checkOutput("arst_tlu_clock", tlu_clock, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_number", number, 0);
    checkOutput("arst_flag", acc_flag, 0);
    tlu_trig = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    tick();
    run_data_hs(16'h3C5A, 2, -1, 1);
    run_ext(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
